// File: rtl/sequence_copier.sv
// ---------------------------------------------------------------------------
// sequence_copier
//
// Read side of the four sequence savers. When the saver named by
// next_copy_from holds a complete sequence, this block reads SEQ_LEN words
// out of it (one-cycle synchronous read) and forwards them one at a time on
// a valid/ready stream. When the last word has been accepted, it pulses that
// saver's copied strobe so the saver can return to RESET.
//
// Ports
//   entry_clock           sole clock, rising edge
//   reset_n               asynchronous active-low reset
//   copy_enable           allows a new job to start (a running job always finishes)
//   next_copy_from[3:0]   one-hot saver to copy next, bits D,C,B,A
//   saved_ready[3:0]      per-saver "complete sequence waiting", bits D,C,B,A
//   A/B/C/D_data          saver read data, valid the cycle after rd_en
//   out_ready             downstream accepts out_data
//   copy_job[3:0]         one-hot saver being copied, 0 when idle
//   rd_en, rd_addr        read strobe and address towards the savers
//   out_data, out_valid,
//   out_last              output stream; out_last marks the final word
//   A/B/C/D_copied        one-cycle end-of-job strobes
//   sel_error             sticky: next_copy_from was not one-hot while a
//                         start was possible
// ---------------------------------------------------------------------------
module sequence_copier #(
    parameter int SEQ_LEN = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
) (
    input  logic              entry_clock,
    input  logic              reset_n,
    input  logic              copy_enable,
    input  logic [3:0]        next_copy_from,
    input  logic [3:0]        saved_ready,
    input  logic [DATA_W-1:0] A_data,
    input  logic [DATA_W-1:0] B_data,
    input  logic [DATA_W-1:0] C_data,
    input  logic [DATA_W-1:0] D_data,
    input  logic              out_ready,
    output logic [3:0]        copy_job,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              A_copied,
    output logic              B_copied,
    output logic              C_copied,
    output logic              D_copied,
    output logic              sel_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic              sel_onehot;
    logic              start;
    logic [DATA_W-1:0] sel_data;

    // x & (x-1) clears the lowest set bit; zero result with x != 0 means one-hot.
    assign sel_onehot = (next_copy_from != 4'd0) &&
                        ((next_copy_from & (next_copy_from - 4'd1)) == 4'd0);
    assign start      = copy_enable && sel_onehot &&
                        ((next_copy_from & saved_ready) != 4'd0);

    assign rd_addr = addr;

    always_ff @(posedge entry_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        copy_job  = 4'd0;
        rd_en     = 1'b0;
        A_copied  = 1'b0;
        B_copied  = 1'b0;
        C_copied  = 1'b0;
        D_copied  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                copy_job  = sel;
                rd_en     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                copy_job  = sel;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                copy_job = sel;
                if (out_ready) begin
                    state_nxt = (addr == LAST_ADDR) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                copy_job  = sel;
                A_copied  = sel[0];
                B_copied  = sel[1];
                C_copied  = sel[2];
                D_copied  = sel[3];
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Data of the latched saver; sel is one-hot for the whole job.
    always_comb begin
        sel_data = '0;
        case (sel)
            4'b0001: sel_data = A_data;
            4'b0010: sel_data = B_data;
            4'b0100: sel_data = C_data;
            4'b1000: sel_data = D_data;
            default: sel_data = '0;
        endcase
    end

    always_ff @(posedge entry_clock or negedge reset_n) begin
        if (!reset_n) begin
            sel       <= 4'd0;
            addr      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sel_error <= 1'b0;
        end else begin
            // Only a start opportunity with a malformed selection is an error.
            if ((state == S_IDLE) && copy_enable && !sel_onehot) begin
                sel_error <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel  <= next_copy_from;
                        addr <= '0;
                    end
                end
                S_WAIT: begin
                    out_data  <= sel_data;
                    out_valid <= 1'b1;
                    out_last  <= (addr == LAST_ADDR);
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        // Address parks at the last word; cleared at the next start.
                        if (addr != LAST_ADDR) begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_copier.sv
module tb_sequence_copier;

    localparam int SEQ_LEN = 16;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;

    logic              entry_clock    = 1'b0;
    logic              reset_n        = 1'b0;
    logic              copy_enable    = 1'b1;
    logic              out_ready      = 1'b0;
    logic [3:0]        next_copy_from = 4'b0001;
    logic [3:0]        saved_ready    = 4'b0000;
    logic [DATA_W-1:0] a_data, b_data, c_data, d_data;
    logic [3:0]        copy_job;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_last;
    logic              a_copied, b_copied, c_copied, d_copied;
    logic              sel_error;
    wire  [3:0]        copied = {d_copied, c_copied, b_copied, a_copied};

    sequence_copier #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .entry_clock(entry_clock), .reset_n(reset_n), .copy_enable(copy_enable),
        .next_copy_from(next_copy_from), .saved_ready(saved_ready),
        .A_data(a_data), .B_data(b_data), .C_data(c_data), .D_data(d_data),
        .out_ready(out_ready), .copy_job(copy_job), .rd_en(rd_en), .rd_addr(rd_addr),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .A_copied(a_copied), .B_copied(b_copied), .C_copied(c_copied), .D_copied(d_copied),
        .sel_error(sel_error)
    );

    always #5 entry_clock = ~entry_clock;

    // Saver model: word appears the cycle after rd_en, garbage otherwise.
    logic [DATA_W-1:0] mem [4][SEQ_LEN];
    always @(posedge entry_clock) begin
        a_data <= rd_en ? mem[0][rd_addr] : DATA_W'($urandom);
        b_data <= rd_en ? mem[1][rd_addr] : DATA_W'($urandom);
        c_data <= rd_en ? mem[2][rd_addr] : DATA_W'($urandom);
        d_data <= rd_en ? mem[3][rd_addr] : DATA_W'($urandom);
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the most recent job.
    logic [DATA_W-1:0] got_d[$];
    logic              got_l[$];
    int pulse_cnt, other_cnt, pulse_n, rd_cnt, addr_bad, hold_bad, job_bad, stalls;

    typedef struct {
        logic [3:0] ncf;
        logic [3:0] sr;
        logic       en;
        logic [3:0] exp_job;
        logic       exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge entry_clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        next_copy_from = 4'b0001;
        saved_ready    = 4'b0000;
        copy_enable    = 1'b1;
        out_ready      = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on word 3,
    // 3: always ready with copy_enable dropped mid-job.
    task automatic run_job(input int k, input int mode);
        int   w, n, words, stall_cnt;
        logic ready, held_v, held_l, done;
        logic [DATA_W-1:0] held_d;
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        got_d.delete();
        got_l.delete();
        pulse_cnt = 0; other_cnt = 0; pulse_n = -1; rd_cnt = 0;
        addr_bad = 0; hold_bad = 0; job_bad = 0; stalls = 0;
        words = 0; stall_cnt = 0; held_v = 1'b0; held_d = '0; held_l = 1'b0; done = 1'b0;
        ready = 1'b1;
        next_copy_from = onehot;
        saved_ready[k] = 1'b1;
        w = 0;
        while (copy_job == 4'd0 && w < 50) begin
            step();
            w++;
        end
        check($sformatf("job_start_%0d", k), copy_job, onehot);
        n = 1;
        while (!done && n < 3000) begin
            if (copy_job != onehot) job_bad++;
            if (rd_en) begin
                if (rd_addr != ADDR_W'(rd_cnt)) addr_bad++;
                rd_cnt++;
            end
            if (held_v && !(out_valid && out_data == held_d && out_last == held_l)) hold_bad++;
            if ((copied & ~onehot) != 4'd0) other_cnt++;
            case (mode)
                1:       ready = 1'($urandom_range(0, 1));
                2:       ready = !(out_valid && words == 3 && stall_cnt < 5);
                default: ready = 1'b1;
            endcase
            if (mode == 2 && !ready) stall_cnt++;
            if (mode == 3 && n == 10) copy_enable = 1'b0;
            out_ready = ready;
            if (out_valid && !ready) stalls++;
            if (out_valid && ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                words++;
            end
            held_v = out_valid && !ready;
            held_d = out_data;
            held_l = out_last;
            if (copied[k]) begin
                pulse_cnt++;
                pulse_n = n;
                saved_ready[k] = 1'b0;
                done = 1'b1;
            end
            step();
            n++;
        end
        check($sformatf("job_end_idle_%0d", k), copy_job, 4'd0);
        check($sformatf("strobe_single_%0d", k), copied, 4'd0);
        copy_enable = 1'b1;
    endtask

    task automatic verify_job(input string tag, input int k, input int exp_n);
        check({tag, "_words"}, got_d.size(), SEQ_LEN);
        for (int i = 0; i < SEQ_LEN && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], mem[k][i]);
            check($sformatf("%s_last%0d", tag, i), got_l[i], (i == SEQ_LEN - 1));
        end
        check({tag, "_pulses"}, pulse_cnt, 1);
        check({tag, "_other_pulses"}, other_cnt, 0);
        check({tag, "_pulse_cycle"}, pulse_n, exp_n);
        check({tag, "_rd_count"}, rd_cnt, SEQ_LEN);
        check({tag, "_addr_seq"}, addr_bad, 0);
        check({tag, "_hold_stable"}, hold_bad, 0);
        check({tag, "_job_stable"}, job_bad, 0);
    endtask

    initial begin
        int w, cnt;

        tbl[0] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0};
        tbl[1] = '{4'b0010, 4'b0001, 1'b1, 4'b0000, 1'b0};
        tbl[2] = '{4'b0011, 4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[3] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[4] = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b0};
        tbl[5] = '{4'b0011, 4'b1111, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{4'b1000, 4'b1100, 1'b1, 4'b1000, 1'b0};
        tbl[7] = '{4'b1100, 4'b1100, 1'b1, 4'b0000, 1'b1};

        for (int k = 0; k < 4; k++)
            for (int i = 0; i < SEQ_LEN; i++)
                mem[k][i] = DATA_W'(((k + 1) << 8) | i);

        // Reset state
        step();
        check("reset_state", {copy_job, rd_en, rd_addr, out_data, out_valid, out_last,
                              copied, sel_error}, 32'd0);
        do_reset();

        // Single job from A, 0x100..0x10F, no backpressure
        run_job(0, 0);
        verify_job("jobA", 0, 3 * SEQ_LEN + 1);

        // Stall of 5 cycles on word 3
        run_job(0, 2);
        verify_job("stallA", 0, 3 * SEQ_LEN + 1 + 5);

        // A -> B -> C -> D
        for (int k = 0; k < 4; k++) begin
            run_job(k, 0);
            verify_job($sformatf("rot%0d", k), k, 3 * SEQ_LEN + 1);
        end

        // Selected saver not ready: normal wait, then start one cycle after ready
        next_copy_from = 4'b0010;
        saved_ready    = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (copy_job != 4'd0 || rd_en) cnt++;
        end
        check("wait_no_job", cnt, 0);
        check("wait_no_error", sel_error, 1'b0);
        saved_ready = 4'b0011;
        step();
        check("late_ready_start", copy_job, 4'b0010);
        run_job(1, 0);
        verify_job("lateB", 1, 3 * SEQ_LEN + 1);
        saved_ready = 4'b0000;

        // copy_enable dropped mid-job
        run_job(2, 3);
        verify_job("enDropC", 2, 3 * SEQ_LEN + 1);

        // Start-condition table
        for (int t = 0; t < 8; t++) begin
            do_reset();
            next_copy_from = tbl[t].ncf;
            saved_ready    = tbl[t].sr;
            copy_enable    = tbl[t].en;
            step();
            step();
            step();
            check($sformatf("tbl%0d_copy_job", t), copy_job, tbl[t].exp_job);
            check($sformatf("tbl%0d_sel_error", t), sel_error, tbl[t].exp_err);
        end

        // sel_error is sticky until reset
        do_reset();
        next_copy_from = 4'b0011;
        saved_ready    = 4'b0011;
        step();
        step();
        check("err_set", sel_error, 1'b1);
        check("err_no_job", copy_job, 4'd0);
        next_copy_from = 4'b0001;
        saved_ready    = 4'b0000;
        repeat (5) step();
        check("err_sticky", sel_error, 1'b1);
        do_reset();
        check("err_cleared", sel_error, 1'b0);

        // Reset during word 7
        for (int i = 0; i < SEQ_LEN; i++) mem[0][i] = DATA_W'(16'h100 + i);
        next_copy_from = 4'b0001;
        saved_ready    = 4'b0001;
        out_ready      = 1'b1;
        w = 0;
        while (!(out_valid && out_data == 16'h107) && w < 100) begin
            step();
            w++;
        end
        check("reach_word7", {out_valid, out_data}, {1'b1, 16'h107});
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {copy_job, rd_en, rd_addr, out_data, out_valid, out_last,
                                  copied, sel_error}, 32'd0);
        cnt = 0;
        repeat (3) begin
            step();
            if (copied != 4'd0 || copy_job != 4'd0) cnt++;
        end
        check("rst_no_strobe", cnt, 0);
        reset_n = 1'b1;
        run_job(0, 0);
        verify_job("afterRst", 0, 3 * SEQ_LEN + 1);

        // Randomized jobs with random backpressure
        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(0, 3);
            for (int i = 0; i < SEQ_LEN; i++) mem[k][i] = DATA_W'($urandom);
            run_job(k, 1);
            verify_job($sformatf("rnd%0d", r), k, 3 * SEQ_LEN + 1 + stalls);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
